// File: rtl/ibex_csr_rmw.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ibex_csr_rmw
// Purpose  : Read-modify-write sequencer in front of a shadowed CSR storage
//            primitive. It accepts one READ/WRITE/SET/CLEAR request at a time
//            and runs it through IDLE -> EXEC -> RESP. In EXEC it reads the CSR,
//            computes the masked new value and strobes the write. In RESP it
//            returns the pre-operation value.
// Ports    : clk_i/rst_i          clock, synchronous active-high reset
//            req_*                request handshake (op, operand)
//            rsp_*                response handshake (old value, error flag)
//            csr_*                storage primitive write strobe/data, read data
//                                 and shadow-mismatch flag
//            err_sticky_o/err_count_o  error history (sticky flag, saturating)
// Revision : 1.0  initial release
// ============================================================================
module ibex_csr_rmw #(
    parameter int unsigned      Width     = 32,
    parameter logic [Width-1:0] WriteMask = {Width{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [Width-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    output logic             csr_wr_en_o,
    output logic [Width-1:0] csr_wr_data_o,
    input  logic [Width-1:0] csr_rd_data_i,
    input  logic             csr_rd_error_i,
    output logic             err_sticky_o,
    output logic [7:0]       err_count_o
);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_SET   = 2'b10;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [1:0]       r_op;
    logic [Width-1:0] r_wdata;
    logic [Width-1:0] r_rsp_rdata;
    logic             r_rsp_error;
    logic             r_err_sticky;
    logic [7:0]       r_err_count;

    logic             w_req_hs;
    logic [Width-1:0] w_next;
    logic [Width-1:0] w_new;
    logic             w_wr_req;

    // Ready is withheld during reset so nothing can be accepted on that edge.
    assign req_ready_o = (r_state == IDLE) && !rst_i;
    assign w_req_hs    = req_valid_i && req_ready_o;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_op         <= c_OP_READ;
            r_wdata      <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_error  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_req_hs) begin
                r_op    <= req_op_i;
                r_wdata <= req_wdata_i;
            end
            if (r_state == EXEC) begin
                // Response always carries the value seen before the write.
                r_rsp_rdata <= csr_rd_data_i;
                r_rsp_error <= csr_rd_error_i;
                if (csr_rd_error_i) begin
                    r_err_sticky <= 1'b1;
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid_i) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read-modify-write datapath (combinational from live CSR read data)
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = csr_rd_data_i;
        case (r_op)
            c_OP_WRITE: w_next = r_wdata;
            c_OP_SET:   w_next = csr_rd_data_i | r_wdata;
            c_OP_CLEAR: w_next = csr_rd_data_i & ~r_wdata;
            default:    w_next = csr_rd_data_i;
        endcase
    end

    // Bits outside WriteMask are carried over from the current CSR value.
    assign w_new = (w_next & WriteMask) | (csr_rd_data_i & ~WriteMask);

    // SET/CLEAR with a zero operand cannot change anything, so no strobe.
    assign w_wr_req = (r_op == c_OP_WRITE) ||
                      (((r_op == c_OP_SET) || (r_op == c_OP_CLEAR)) && (r_wdata != '0));

    assign csr_wr_en_o   = (r_state == EXEC) && !rst_i && !csr_rd_error_i && w_wr_req;
    assign csr_wr_data_o = (r_state == EXEC) ? w_new : '0;

    assign rsp_valid_o  = (r_state == RESP);
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_error_o  = r_rsp_error;
    assign err_sticky_o = r_err_sticky;
    assign err_count_o  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ibex_csr_rmw.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ibex_csr_rmw
// Purpose  : Scoreboard bench for ibex_csr_rmw. The driver pushes expected
//            writes and responses from a reference model; a monitor pops and
//            compares whenever the DUT strobes a write or completes a response.
//            A second instance with a partial WriteMask covers masking.
// Revision : 1.0  initial release
// ============================================================================
module tb_ibex_csr_rmw;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        csr_rd_error;
    logic [31:0] csr_mem;
    logic        preload_en;
    logic [31:0] preload_val;

    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        csr_wr_en_o;
    logic [31:0] csr_wr_data_o;
    logic        err_sticky_o;
    logic [7:0]  err_count_o;

    // Masked instance signals
    logic        m_req_valid;
    logic [1:0]  m_req_op;
    logic [31:0] m_req_wdata;
    logic        m_rsp_ready;
    logic [31:0] m_csr_rd;
    logic        m_csr_err;
    logic        m_req_ready;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_error;
    logic        m_wr_en;
    logic [31:0] m_wr_data;
    logic        m_sticky;
    logic [7:0]  m_count;

    ibex_csr_rmw dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_error_o    (rsp_error_o),
        .csr_wr_en_o    (csr_wr_en_o),
        .csr_wr_data_o  (csr_wr_data_o),
        .csr_rd_data_i  (csr_mem),
        .csr_rd_error_i (csr_rd_error),
        .err_sticky_o   (err_sticky_o),
        .err_count_o    (err_count_o)
    );

    ibex_csr_rmw #(.Width(32), .WriteMask(32'h0000_FFFF)) dut_m (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (m_req_valid),
        .req_ready_o    (m_req_ready),
        .req_op_i       (m_req_op),
        .req_wdata_i    (m_req_wdata),
        .rsp_valid_o    (m_rsp_valid),
        .rsp_ready_i    (m_rsp_ready),
        .rsp_rdata_o    (m_rsp_rdata),
        .rsp_error_o    (m_rsp_error),
        .csr_wr_en_o    (m_wr_en),
        .csr_wr_data_o  (m_wr_data),
        .csr_rd_data_i  (m_csr_rd),
        .csr_rd_error_i (m_csr_err),
        .err_sticky_o   (m_sticky),
        .err_count_o    (m_count)
    );

    // CSR storage model: bench preload or DUT write
    always @(posedge clk) begin
        if (preload_en)       csr_mem <= preload_val;
        else if (csr_wr_en_o) csr_mem <= csr_wr_data_o;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  cnt;
        logic        sticky;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] wq[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [31:0] ref_csr;
    int          ref_cnt;
    bit          ref_sticky;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] model_new(input logic [1:0] op, input logic [31:0] old,
                                              input logic [31:0] wd, input logic [31:0] mask);
        logic [31:0] nxt;
        case (op)
            2'd1:    nxt = wd;
            2'd2:    nxt = old | wd;
            2'd3:    nxt = old & ~wd;
            default: nxt = old;
        endcase
        return (nxt & mask) | (old & ~mask);
    endfunction

    // Monitor: compare every write strobe and every completed response
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("wr_en_during_reset", {31'd0, csr_wr_en_o}, 32'd0);
            end else begin
                if (csr_wr_en_o) begin
                    if (wq.size() == 0) fail_now("unexpected_csr_write");
                    else chk("csr_wr_data", csr_wr_data_o, wq.pop_front());
                end
                if (rsp_valid_o && rsp_ready) begin
                    if (rq.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        e = rq.pop_front();
                        chk("rsp_rdata", rsp_rdata_o, e.rdata);
                        chk("rsp_error", {31'd0, rsp_error_o}, {31'd0, e.err});
                        chk("err_count", {24'd0, err_count_o}, {24'd0, e.cnt});
                        chk("err_sticky", {31'd0, err_sticky_o}, {31'd0, e.sticky});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] v);
        preload_val = v;
        preload_en  = 1'b1;
        tick();
        preload_en  = 1'b0;
        ref_csr     = v;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!req_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready_o) fail_now(name);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] wd, input bit err, input int hold);
        rsp_t e;
        bit   wr;
        wait_idle("timeout_before_request");
        wr = !err && (op == 2'd1 || (op != 2'd0 && wd != 32'd0));
        e.rdata = ref_csr;
        e.err   = err;
        if (err) begin
            ref_sticky = 1'b1;
            if (ref_cnt < 255) ref_cnt++;
        end
        e.cnt    = ref_cnt[7:0];
        e.sticky = ref_sticky;
        if (wr) begin
            ref_csr = model_new(op, ref_csr, wd, 32'hFFFF_FFFF);
            wq.push_back(ref_csr);
        end
        rq.push_back(e);

        req_valid    = 1'b1;
        req_op       = op;
        req_wdata    = wd;
        csr_rd_error = err;
        rsp_ready    = (hold == 0);
        tick();                      // handshake edge, now in EXEC
        req_valid = 1'b0;
        req_op    = 2'($urandom);    // latched copy must be used, not the live port
        req_wdata = $urandom;
        if (hold > 0) begin
            tick();                  // now in RESP
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'b1;    // must be ignored outside IDLE
                @(negedge clk);
                chk("hold_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
                chk("hold_rsp_rdata", rsp_rdata_o, e.rdata);
                chk("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
                tick();
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            tick();
            chk("idle_after_release", {31'd0, req_ready_o}, 32'd1);
        end
        wait_idle("timeout_response");
        csr_rd_error = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_wdata = '0;
        rsp_ready = 1'b0; csr_rd_error = 1'b0; preload_en = 1'b0; preload_val = '0;
        m_req_valid = 1'b0; m_req_op = 2'd0; m_req_wdata = '0; m_rsp_ready = 1'b0;
        m_csr_rd = 32'hAAAA_0000; m_csr_err = 1'b0;
        ref_csr = '0; ref_cnt = 0; ref_sticky = 1'b0;

        tick();
        preload(32'h0000_00F0);
        tick();
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready_o}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("reset_rsp_error", {31'd0, rsp_error_o}, 32'd0);
        chk("reset_err_sticky", {31'd0, err_sticky_o}, 32'd0);
        chk("reset_err_count", {24'd0, err_count_o}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready_o}, 32'd1);

        // Directed basics
        preload(32'h0000_00F0);
        do_req(2'd1, 32'h1234_5678, 1'b0, 0);
        preload(32'h0000_00F0);
        do_req(2'd2, 32'h0000_000F, 1'b0, 0);
        preload(32'h0000_00F0);
        do_req(2'd3, 32'h0000_00F0, 1'b0, 0);
        preload(32'h0000_00F0);
        do_req(2'd2, 32'h0, 1'b0, 0);
        do_req(2'd3, 32'h0, 1'b0, 0);
        do_req(2'd0, 32'hFFFF_FFFF, 1'b0, 0);

        // Backpressure
        do_req(2'd0, 32'h0, 1'b0, 5);
        do_req(2'd1, $urandom, 1'b0, 5);

        // Single errored write
        do_req(2'd1, 32'h0000_DEAD, 1'b1, 0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [31:0] wd;
            int          hold;
            wd   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            do_req(2'($urandom_range(0, 3)), wd, ($urandom_range(0, 7) == 0), hold);
        end

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            do_req(2'($urandom_range(0, 3)), $urandom, 1'b1, 0);
        end
        chk("err_count_saturated", {24'd0, err_count_o}, 32'd255);
        do_req(2'd1, $urandom, 1'b0, 0);

        // Masked instance
        m_req_valid = 1'b1; m_req_op = 2'd1; m_req_wdata = 32'hFFFF_FFFF; m_rsp_ready = 1'b1;
        tick();
        m_req_valid = 1'b0;
        @(negedge clk);
        chk("mask_wr_en", {31'd0, m_wr_en}, 32'd1);
        chk("mask_write_data", m_wr_data, model_new(2'd1, m_csr_rd, 32'hFFFF_FFFF, 32'h0000_FFFF));
        tick();
        @(negedge clk);
        chk("mask_rsp_rdata", m_rsp_rdata, 32'hAAAA_0000);
        tick();
        m_req_valid = 1'b1; m_req_op = 2'd2; m_req_wdata = 32'hFFFF_0001;
        tick();
        m_req_valid = 1'b0;
        @(negedge clk);
        chk("mask_set_data", m_wr_data, 32'hAAAA_0001);
        tick();
        tick();

        // Reset asserted while in EXEC
        preload(32'h0000_1111);
        wait_idle("timeout_before_reset_test");
        req_valid = 1'b1; req_op = 2'd1; req_wdata = 32'h0000_0055; rsp_ready = 1'b1;
        tick();                      // EXEC
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_wr_en", {31'd0, csr_wr_en_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("rst_exec_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_exec_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_exec_err_count", {24'd0, err_count_o}, 32'd0);
        chk("rst_exec_err_sticky", {31'd0, err_sticky_o}, 32'd0);
        chk("rst_exec_req_ready", {31'd0, req_ready_o}, 32'd0);
        tick();
        rst = 1'b0;
        ref_cnt = 0;
        ref_sticky = 1'b0;
        do_req(2'd0, 32'h0, 1'b0, 0);  // dropped write must not have landed

        tick();
        tick();
        chk("pending_writes", wq.size(), 32'd0);
        chk("pending_responses", rq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ibex_csr_rmw.md
IBEX_CSR_RMW -- requirements
Module: ibex_csr_rmw

Interface
REQ-001 Parameter Width, default 32, data width of request, response and CSR ports.
REQ-002 Parameter WriteMask [Width-1:0], default all ones, bits allowed to change; masked-off bits keep the old CSR value.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  block can accept a request.
REQ-007 req_op_i  input  2  00 READ, 01 WRITE, 10 SET, 11 CLEAR.
REQ-008 req_wdata_i  input  Width  operand.
REQ-009 rsp_valid_o  output  1  response present.
REQ-010 rsp_ready_i  input  1  consumer accepts response.
REQ-011 rsp_rdata_o  output  Width  CSR value before the operation.
REQ-012 rsp_error_o  output  1  shadow-copy mismatch detected on this access.
REQ-013 csr_wr_en_o  output  1  write strobe to the CSR storage primitive.
REQ-014 csr_wr_data_o  output  Width  write data to the CSR storage primitive.
REQ-015 csr_rd_data_i  input  Width  current CSR value from the primitive.
REQ-016 csr_rd_error_i  input  1  shadow mismatch flag from the primitive.
REQ-017 err_sticky_o  output  1  set on any detected error, cleared only by reset.
REQ-018 err_count_o  output  8  saturating count of errored accesses.

Function
REQ-019 FSM states IDLE, EXEC, RESP; exactly one request in flight.
REQ-020 req_ready_o SHALL be 1 only in IDLE; handshake = req_valid_i & req_ready_o at a rising edge, which latches op and wdata and moves to EXEC.
REQ-021 EXEC lasts exactly one cycle: samples csr_rd_data_i and csr_rd_error_i into the response registers, then moves to RESP.
REQ-022 Next value in EXEC: WRITE -> wdata; SET -> old | wdata; CLEAR -> old & ~wdata; then new = (next & WriteMask) | (old & ~WriteMask).
REQ-023 csr_wr_en_o SHALL be 1 only in EXEC, with rst_i low, csr_rd_error_i low, and op WRITE, or op SET/CLEAR with latched wdata != 0.
REQ-024 csr_wr_data_o SHALL equal new (REQ-022) in EXEC and 0 otherwise; both CSR outputs are combinational from state, latched request and csr_rd_data_i.
REQ-025 READ SHALL never assert csr_wr_en_o.
REQ-026 rsp_valid_o SHALL be 1 throughout RESP and hold rsp_rdata_o/rsp_error_o stable until rsp_valid_o & rsp_ready_i, then return to IDLE.
REQ-027 Latency: request accepted at edge N -> CSR write at edge N+1 -> rsp_valid_o high from N+1 to earliest N+2 completion; peak throughput one request per 3 cycles.
REQ-028 rsp_rdata_o SHALL be the pre-write value, even for masked or suppressed writes.
REQ-029 On csr_rd_error_i in EXEC: write suppressed, rsp_error_o = 1, err_sticky_o set, err_count_o incremented, saturating at 255 (no wrap).
REQ-030 rsp_ready_i outside RESP and req_valid_i outside IDLE SHALL be ignored.

Reset
REQ-031 rst_i high at a rising edge SHALL force IDLE, rsp_valid_o 0, rsp_rdata_o 0, rsp_error_o 0, err_sticky_o 0, err_count_o 0, latched request 0.
REQ-032 While rst_i is high, csr_wr_en_o SHALL be 0 and req_ready_o SHALL be 0, including reset asserted during EXEC or RESP; an in-flight request is dropped without response.
REQ-033 First request is accepted at the first rising edge with rst_i low.

Verification
REQ-034 CSR holds 0x0000_00F0, WRITE 0x1234_5678, rsp_ready_i=1 -> one-cycle csr_wr_en_o with data 0x1234_5678; rsp_rdata_o 0x0000_00F0, rsp_error_o 0.
REQ-035 CSR 0x0000_00F0: SET 0x0F -> write 0xFF; CLEAR 0xF0 -> write 0x00; SET 0 and CLEAR 0 -> no csr_wr_en_o, rdata returned.
REQ-036 WriteMask 0x0000_FFFF, CSR 0xAAAA_0000, WRITE 0xFFFF_FFFF -> csr_wr_data_o 0xAAAA_FFFF.
REQ-037 csr_rd_error_i=1 during EXEC of WRITE -> no write, rsp_error_o 1, err_sticky_o 1; 300 errored accesses -> err_count_o 255.
REQ-038 rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and data stable, req_ready_o 0, new req_valid_i ignored; release -> IDLE next cycle.
REQ-039 rst_i asserted in EXEC -> no csr_wr_en_o that cycle, no response, all outputs at reset values next cycle.
